// File: rtl/signed_sum_arbiter.sv
// signed_sum_arbiter: round-robin access for NUM_REQ requesters to one shared 4-operand signed adder.
// Build with `SUM_ARB_OVF_COUNT_EN defined to add a saturating ovf_count output.
module signed_sum_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    parameter int ID_W    = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*4*WIDTH-1:0]   ops,
    output logic [NUM_REQ-1:0]           grant,
    output logic [WIDTH-1:0]             add_a,
    output logic [WIDTH-1:0]             add_b,
    output logic [WIDTH-1:0]             add_c,
    output logic [WIDTH-1:0]             add_d,
    input  logic [WIDTH-1:0]             add_sum,
    input  logic                         add_ovf,
    output logic [WIDTH-1:0]             sum_out,
    output logic                         ovf_out,
    output logic                         done,
    output logic [ID_W-1:0]              done_id,
`ifdef SUM_ARB_OVF_COUNT_EN
    output logic [7:0]                   ovf_count,
`endif
    output logic                         busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] EVAL  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]         state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    gid;
    logic [ID_W-1:0]    pick;
    logic [ID_W:0]      cand;
    logic               found;
    logic [4*WIDTH-1:0] slice [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign slice[i] = ops[i*4*WIDTH +: 4*WIDTH];
    end

    // First set request at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ))
                cand = cand - (ID_W+1)'(NUM_REQ);
            if (!found && req[cand[ID_W-1:0]]) begin
                found = 1'b1;
                pick  = cand[ID_W-1:0];
            end
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            gid     <= '0;
            grant   <= '0;
            add_a   <= '0;
            add_b   <= '0;
            add_c   <= '0;
            add_d   <= '0;
            sum_out <= '0;
            ovf_out <= 1'b0;
            done    <= 1'b0;
            done_id <= '0;
`ifdef SUM_ARB_OVF_COUNT_EN
            ovf_count <= '0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        grant <= NUM_REQ'(1) << pick;
                        gid   <= pick;
                        {add_d, add_c, add_b, add_a} <= slice[pick];
                        state <= DRIVE;
                    end
                end
                DRIVE: state <= EVAL;
                EVAL: begin
                    if (req[gid]) begin
                        sum_out <= add_sum;
                        ovf_out <= add_ovf;
                        done_id <= gid;
                        state   <= RESP;
                    end else begin
                        grant <= '0;
                        state <= IDLE;
                    end
                end
                RESP: begin
                    done  <= 1'b1;
                    grant <= '0;
                    state <= IDLE;
                    if (gid == ID_W'(NUM_REQ-1))
                        rr_ptr <= '0;
                    else
                        rr_ptr <= gid + 1'b1;
`ifdef SUM_ARB_OVF_COUNT_EN
                    if (ovf_out && ovf_count != 8'hFF)
                        ovf_count <= ovf_count + 8'd1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_signed_sum_arbiter.sv
// tb_signed_sum_arbiter: directed vectors plus hand sequences for signed_sum_arbiter.
// Models the external 4-input signed adder; works with or without SUM_ARB_OVF_COUNT_EN.
module tb_signed_sum_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [63:0] ops;
    logic [3:0]  grant;
    logic [3:0]  add_a, add_b, add_c, add_d;
    logic [3:0]  add_sum;
    logic        add_ovf;
    logic [3:0]  sum_out;
    logic        ovf_out;
    logic        done;
    logic [1:0]  done_id;
    logic        busy;
`ifdef SUM_ARB_OVF_COUNT_EN
    logic [7:0]  ovf_count;
`endif

    int errors = 0;
    int checks = 0;
    int bad_onehot = 0;

    signed_sum_arbiter #(.NUM_REQ(4), .WIDTH(4), .ID_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ops(ops), .grant(grant),
        .add_a(add_a), .add_b(add_b), .add_c(add_c), .add_d(add_d),
        .add_sum(add_sum), .add_ovf(add_ovf),
        .sum_out(sum_out), .ovf_out(ovf_out),
        .done(done), .done_id(done_id),
`ifdef SUM_ARB_OVF_COUNT_EN
        .ovf_count(ovf_count),
`endif
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared external adder: true signed sum, wrapped to 4 bits, overflow if out of range.
    int s;
    always_comb begin
        s = int'($signed(add_a)) + int'($signed(add_b))
          + int'($signed(add_c)) + int'($signed(add_d));
        add_sum = s[3:0];
        add_ovf = (s > 7) || (s < -8);
    end

    always @(negedge clk)
        if (rst_n && !$onehot0(grant)) bad_onehot++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!done && cyc < limit);
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL wait_done: no done within %0d cycles", limit);
        end
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [63:0] ops;
        logic [3:0]  sum;
        logic        ovf;
        logic [1:0]  id;
    } vec_t;

    vec_t tv[5];
    int   cyc;
    logic [1:0] rr_exp [5];

    initial begin
        tv[0] = '{4'b0001, 64'h0000_0000_0000_1F23, 4'h5, 1'b0, 2'd0};
        tv[1] = '{4'b0100, 64'h0000_E347_0000_0000, 4'hC, 1'b1, 2'd2};
        tv[2] = '{4'b0100, 64'h0000_FEDA_0000_0000, 4'h4, 1'b1, 2'd2};
        tv[3] = '{4'b0010, 64'h0000_0000_FFFF_0000, 4'hC, 1'b0, 2'd1};
        tv[4] = '{4'b1000, 64'h7FC8_0000_0000_0000, 4'hA, 1'b0, 2'd3};
        rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        rst_n = 1'b0;
        req   = '0;
        ops   = '0;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rst_grant", grant, 0);
        chk("rst_sum", sum_out, 0);
        chk("rst_ovf", ovf_out, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_add", {add_d, add_c, add_b, add_a}, 0);

        for (int i = 0; i < 5; i++) begin
            ops = tv[i].ops;
            req = tv[i].req;
            step();
            chk($sformatf("v%0d_grant", i), grant, tv[i].req);
            chk($sformatf("v%0d_busy", i), busy, 1);
            step();
            chk($sformatf("v%0d_early1", i), done, 0);
            step();
            chk($sformatf("v%0d_early2", i), done, 0);
            step();
            chk($sformatf("v%0d_done", i), done, 1);
            chk($sformatf("v%0d_sum", i), sum_out, tv[i].sum);
            chk($sformatf("v%0d_ovf", i), ovf_out, tv[i].ovf);
            chk($sformatf("v%0d_id", i), done_id, tv[i].id);
            chk($sformatf("v%0d_gclr", i), grant, 0);
            req = '0;
            step();
            chk($sformatf("v%0d_pulse", i), done, 0);
        end
`ifdef SUM_ARB_OVF_COUNT_EN
        chk("ovf_count", ovf_count, 2);
`endif

        // Reset taken while in EVAL.
        ops = 64'h7FC8_0000_0000_0000;
        req = 4'b1000;
        step();
        chk("rm_grant", grant, 4'b1000);
        step();
        rst_n = 1'b0;
        step();
        chk("rm_grant0", grant, 0);
        chk("rm_add0", {add_d, add_c, add_b, add_a}, 0);
        chk("rm_sum0", sum_out, 0);
        chk("rm_ovf0", ovf_out, 0);
        chk("rm_done0", done, 0);
        chk("rm_id0", done_id, 0);
        chk("rm_busy0", busy, 0);
        rst_n = 1'b1;
        wait_done(8, cyc);
        chk("rm_lat", cyc, 4);
        chk("rm_sum", sum_out, 4'hA);
        chk("rm_ovf", ovf_out, 0);
        chk("rm_id", done_id, 3);
        req = '0;
        step();

        // All four requesting: strict rotation, one done every 4 cycles.
        ops = 64'h0003_0002_0001_0000;
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_done(8, cyc);
            chk($sformatf("rr%0d_gap", n), cyc, 4);
            chk($sformatf("rr%0d_id", n), done_id, rr_exp[n]);
            chk($sformatf("rr%0d_sum", n), sum_out, {2'b00, rr_exp[n]});
        end
        req = '0;
        step();

        // Abort: requester 1 drops req during DRIVE.
        ops = 64'h0000_0000_0011_0000;
        req = 4'b0010;
        step();
        chk("ab_grant", grant, 4'b0010);
        req = '0;
        step();
        chk("ab_done1", done, 0);
        step();
        chk("ab_grant0", grant, 0);
        chk("ab_busy0", busy, 0);
        chk("ab_sum", sum_out, 0);
        chk("ab_done2", done, 0);
        step();
        chk("ab_done3", done, 0);
        req = 4'b1011;
        wait_done(8, cyc);
        chk("ab_next_id", done_id, 1);
        chk("ab_next_sum", sum_out, 4'h2);
        req = '0;
        step();

        // Operands changed after grant are ignored.
        ops = '0;
        req = 4'b0100;
        step();
        chk("os_grant", grant, 4'b0100);
        ops = 64'h7777_7777_7777_7777;
        wait_done(8, cyc);
        chk("os_sum", sum_out, 0);
        chk("os_ovf", ovf_out, 0);
        chk("os_id", done_id, 2);
        chk("os_add", {add_d, add_c, add_b, add_a}, 0);
        req = '0;
        step();

        chk("grant_onehot0", bad_onehot, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/signed_sum_arbiter.md
Name: signed_sum_arbiter

Overview:
- Round-robin scheduler sharing one external combinational signed_sum_4inputs adder (4 signed operands -> sum, overflow) among NUM_REQ requesters.
- Each requester presents four signed operands and holds a request. The block grants one requester at a time, drives the adder, registers sum/overflow and returns a one-cycle done pulse tagged with the requester id.
- Sits between the operand sources and the shared adder instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 4, operand/sum width, two's complement.
- ID_W, 2, width of requester id; must be at least clog2(NUM_REQ).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- req  input  NUM_REQ  level request per requester; held until done for that id.
- ops  input  NUM_REQ*4*WIDTH  packed operands; requester i slice [i*4*WIDTH +: 4*WIDTH] = {D,C,B,A}, A at LSBs.
- grant  output  NUM_REQ  one-hot, registered; high from ARB exit through RESP.
- add_a, add_b, add_c, add_d  output  WIDTH each  registered operands to shared adder.
- add_sum  input  WIDTH  adder result.
- add_ovf  input  1  adder overflow.
- sum_out  output  WIDTH  captured signed result, held until next capture.
- ovf_out  output  1  captured overflow, held with sum_out.
- done  output  1  one-cycle pulse, result valid.
- done_id  output  ID_W  id of the completed requester, valid with done, held after.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset (rst_n low at clk edge):
  - grant=0, add_a..add_d=0, sum_out=0, ovf_out=0, done=0, done_id=0, busy=0.
  - rr_ptr=0, state=IDLE.
  - Reset mid-transaction aborts it; no done is issued.
- FSM states: IDLE, DRIVE, EVAL, RESP.
- IDLE:
  - If req!=0, select the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Register grant one-hot and add_a..add_d from that requester's slice.
  - Next state DRIVE.
  - If req==0, stay in IDLE.
- DRIVE: one settle cycle, operands stable on the adder. Next state EVAL.
- EVAL:
  - If the granted req bit is still high: sum_out<=add_sum, ovf_out<=add_ovf, done_id<=granted id. Next state RESP.
  - If it has dropped: abort. grant<=0, go to IDLE, outputs unchanged, rr_ptr unchanged.
- RESP:
  - done=1 for exactly this cycle.
  - rr_ptr<=granted id+1 (wrapping modulo NUM_REQ).
  - grant<=0. Next state IDLE.
- Latency: req sampled in IDLE at edge N -> grant visible after N -> done high during the cycle after edge N+3. Throughput is one transaction per 4 cycles.
- Requester protocol: the requester may drop req on the cycle done is seen, or keep it high to re-request. A re-request is not served back-to-back if another requester is waiting (rr_ptr has advanced past it).
- Operand changes on ops after grant are ignored; operands are latched at grant.
- Requests arriving while busy wait; there is no loss and no queueing beyond the level req.
- add_a..add_d retain their last values in IDLE.
- Arithmetic is performed entirely in the external adder; this block does no width extension.

Optional Feature:
- Macro SUM_ARB_OVF_COUNT_EN.
- Defined:
  - Adds output ovf_count [7:0], reset 0.
  - Increments in RESP when ovf_out=1.
  - Saturates at 255; no wrap.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Single requester: req=0001, slice0 A=3 B=2 C=-1 D=1 -> grant=0001 one cycle after req, done 4 cycles after req, sum_out=5, ovf_out=0, done_id=0.
- Overflow, positive: requester 2 with A=7 B=4 C=3 D=-2 -> sum_out=-4 (4'b1100), ovf_out=1, done_id=2. Also A=-6 B=-3 C=-2 D=-1 -> sum_out=4, ovf_out=1. With SUM_ARB_OVF_COUNT_EN, ovf_count=2 after both.
- Round-robin fairness: req=1111 held continuously -> done_id sequence 0,1,2,3,0, one done every 4 cycles, grant always one-hot.
- Abort: requester 1 drops req during DRIVE -> no done, sum_out unchanged, returns to IDLE; requester 1 is served first on next request (rr_ptr unchanged).
- Reset mid-operation: rst_n=0 in EVAL with operands A=-8 B=-4 C=-1 D=7 -> next cycle all outputs 0, busy=0. Rerun after reset -> sum_out=-6, ovf_out=0.
- Operand stability: change ops slice after grant -> result reflects the operands latched at grant (0+0+0+0 -> 0, not the new values).
